pr_dm_cmd_gen: RTL and testbench

Downstream stage of the PR controller's AXI-Lite command front end. Accepts 80-bit PR commands (opcode, 40-bit address, 32-bit byte size) over a valid/ready stream and splits each into one or more AXI DataMover MM2S commands of at most CHUNK_BYTES. It tracks the DataMover status returns and reports per-command completion (prRwDone) and errors (prRwError, dmError) back to the front end.

---
 rtl/pr_dm_cmd_gen.sv | 155 +++++++++++++++
 tb/tb_pr_dm_cmd_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pr_dm_cmd_gen.sv
// Splits PR commands into DataMover MM2S commands of at most CHUNK_BYTES and tracks their status returns.
// Latency: first DataMover command one cycle after acceptance; completion two cycles after the last status.
// Backpressure: cmd_Tready only in idle; issue stalls on m_dm_cmd_tready or at MAX_OUTSTANDING in flight.
//
// Ports:
//   aclk, aresetn                      clock, synchronous active-low reset
//   cmd_Tdata/Tvalid/Tready            {opcode[79:72], address[71:32], size[31:0]} command stream
//   m_dm_cmd_tdata/tvalid/tready       DataMover MM2S command stream
//   s_dm_sts_tdata/tvalid/tready       DataMover status stream {okay, slverr, decerr, interr, tag[3:0]}
//   prRwDone, prRwError                per-command completion pulse and {illegal, bus error}
//   dmError                            interr, tag mismatch or unexpected status
module pr_dm_cmd_gen #(
    parameter logic [31:0] CHUNK_BYTES     = 32'h0040_0000,
    parameter int          MAX_OUTSTANDING = 4
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [79:0] cmd_Tdata,
    input  logic        cmd_Tvalid,
    output logic        cmd_Tready,
    output logic [79:0] m_dm_cmd_tdata,
    output logic        m_dm_cmd_tvalid,
    input  logic        m_dm_cmd_tready,
    input  logic [7:0]  s_dm_sts_tdata,
    input  logic        s_dm_sts_tvalid,
    output logic        s_dm_sts_tready,
    output logic        prRwDone,
    output logic [1:0]  prRwError,
    output logic        dmError
);

    localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t      state;
    logic        run;          // low for the cycle(s) in reset, gates the ready outputs
    logic [39:0] addr;
    logic [31:0] remaining;
    logic [3:0]  tag;
    logic [3:0]  outstanding;
    logic [3:0]  exp_tag;
    logic        err_sticky;
    logic        illegal;
    logic        dm_error_q;

    logic        cmd_hs;
    logic        issue_hs;
    logic        sts_hs;
    logic        sts_expected;
    logic        cmd_legal;
    logic        eof;
    logic [31:0] btt;
    logic        okay_unused;

    assign okay_unused  = s_dm_sts_tdata[7];

    assign cmd_Tready      = run && (state == ST_IDLE);
    assign s_dm_sts_tready = run;
    assign cmd_hs          = cmd_Tvalid && cmd_Tready;
    assign cmd_legal       = (cmd_Tdata[79:72] == 8'h01) && (cmd_Tdata[31:0] != 32'h0);

    assign eof = (remaining <= CHUNK_BYTES);
    assign btt = eof ? remaining : CHUNK_BYTES;

    assign m_dm_cmd_tvalid = (state == ST_ISSUE) && (outstanding < MAX_OUT);
    // Fields come straight from registers that only change on an issue handshake,
    // so the word holds steady while the DataMover stalls.
    assign m_dm_cmd_tdata  = (state == ST_ISSUE) ?
                             {4'h0, tag, addr, 1'b0, eof, 6'h00, 1'b1, btt[22:0]} : 80'h0;
    assign issue_hs        = m_dm_cmd_tvalid && m_dm_cmd_tready;

    assign sts_hs       = s_dm_sts_tvalid && s_dm_sts_tready;
    assign sts_expected = sts_hs && (outstanding != 4'h0);

    assign prRwDone  = (state == ST_DONE);
    assign prRwError = prRwDone ? {illegal, err_sticky} : 2'b00;
    assign dmError   = dm_error_q;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state       <= ST_IDLE;
            run         <= 1'b0;
            addr        <= 40'h0;
            remaining   <= 32'h0;
            tag         <= 4'h0;
            outstanding <= 4'h0;
            exp_tag     <= 4'h0;
            err_sticky  <= 1'b0;
            illegal     <= 1'b0;
            dm_error_q  <= 1'b0;
        end else begin
            run <= 1'b1;

            // Status tracking runs in every state so stray beats are always flagged.
            dm_error_q <= sts_hs && (s_dm_sts_tdata[4] ||
                                     (s_dm_sts_tdata[3:0] != exp_tag) ||
                                     (outstanding == 4'h0));
            if (sts_hs) begin
                exp_tag <= exp_tag + 4'h1;
                if (s_dm_sts_tdata[6] || s_dm_sts_tdata[5])
                    err_sticky <= 1'b1;
            end

            // An unexpected beat must not underflow the in-flight count.
            case ({issue_hs, sts_expected})
                2'b10:   outstanding <= outstanding + 4'h1;
                2'b01:   outstanding <= outstanding - 4'h1;
                default: outstanding <= outstanding;
            endcase

            case (state)
                ST_IDLE: begin
                    if (cmd_hs) begin
                        addr       <= cmd_Tdata[71:32];
                        remaining  <= cmd_Tdata[31:0];
                        err_sticky <= 1'b0;
                        if (cmd_legal) begin
                            state <= ST_ISSUE;
                        end else begin
                            // Illegal commands pass through drain (nothing is in flight)
                            // so they complete with the same two-cycle latency.
                            illegal <= 1'b1;
                            state   <= ST_DRAIN;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (issue_hs) begin
                        addr      <= addr + {8'h00, btt};
                        remaining <= remaining - btt;
                        tag       <= tag + 4'h1;
                        if (eof)
                            state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (outstanding == 4'h0)
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    illegal <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pr_dm_cmd_gen.sv
// Directed bench for pr_dm_cmd_gen with MAX_OUTSTANDING=2 and a 4 MiB chunk size.
// Latency: checks sample one time unit after the rising edge, inputs change at the same point.
// Backpressure: DataMover ready is driven directly to exercise stalls and the outstanding limit.
module tb_pr_dm_cmd_gen;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [79:0] cmd_Tdata = 80'h0;
    logic        cmd_Tvalid = 1'b0;
    logic        cmd_Tready;
    logic [79:0] m_dm_cmd_tdata;
    logic        m_dm_cmd_tvalid;
    logic        m_dm_cmd_tready = 1'b1;
    logic [7:0]  s_dm_sts_tdata = 8'h0;
    logic        s_dm_sts_tvalid = 1'b0;
    logic        s_dm_sts_tready;
    logic        prRwDone;
    logic [1:0]  prRwError;
    logic        dmError;

    int n_chk  = 0;
    int n_pass = 0;

    logic [79:0] cap[$];
    int          vld_cycles = 0;
    int          dm_err_cnt = 0;
    int          vld_before;
    logic [79:0] w2;

    always #5 aclk = ~aclk;

    pr_dm_cmd_gen #(
        .CHUNK_BYTES     (32'h0040_0000),
        .MAX_OUTSTANDING (2)
    ) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .cmd_Tdata       (cmd_Tdata),
        .cmd_Tvalid      (cmd_Tvalid),
        .cmd_Tready      (cmd_Tready),
        .m_dm_cmd_tdata  (m_dm_cmd_tdata),
        .m_dm_cmd_tvalid (m_dm_cmd_tvalid),
        .m_dm_cmd_tready (m_dm_cmd_tready),
        .s_dm_sts_tdata  (s_dm_sts_tdata),
        .s_dm_sts_tvalid (s_dm_sts_tvalid),
        .s_dm_sts_tready (s_dm_sts_tready),
        .prRwDone        (prRwDone),
        .prRwError       (prRwError),
        .dmError         (dmError)
    );

    // Passive monitor on the falling edge: record issued commands and pulses.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (m_dm_cmd_tvalid && m_dm_cmd_tready)
                cap.push_back(m_dm_cmd_tdata);
            if (m_dm_cmd_tvalid)
                vld_cycles++;
            if (dmError)
                dm_err_cnt++;
        end
    end

    task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic logic [79:0] dm_word(input logic [3:0] t, input logic [39:0] a,
                                            input logic e, input logic [22:0] b);
        return {4'h0, t, a, 1'b0, e, 6'h00, 1'b1, b};
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [39:0] a, input logic [31:0] sz);
        logic ok;
        ok = 1'b0;
        cmd_Tdata  = {op, a, sz};
        cmd_Tvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (cmd_Tready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
        cmd_Tvalid = 1'b0;
        chk("cmd_accepted", 80'(ok), 80'(1));
    endtask

    task automatic send_sts(input logic [7:0] s);
        s_dm_sts_tdata  = s;
        s_dm_sts_tvalid = 1'b1;
        tick();
        s_dm_sts_tvalid = 1'b0;
    endtask

    task automatic wait_cap(input int n);
        for (int i = 0; i < 40 && cap.size() < n; i++)
            tick();
        chk("issued_count", 80'(cap.size()), 80'(n));
    endtask

    // Called right after the final status beat: checks done at S+2, ready at S+3.
    task automatic expect_done(input string name, input logic [1:0] err);
        chk({name, "_done_s1"}, 80'(prRwDone), 80'(0));
        tick();
        chk({name, "_done_s2"}, 80'(prRwDone), 80'(1));
        chk({name, "_err"}, 80'(prRwError), 80'(err));
        tick();
        chk({name, "_done_s3"}, 80'(prRwDone), 80'(0));
        chk({name, "_ready_s3"}, 80'(cmd_Tready), 80'(1));
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        tick();
        tick();
        chk("rst_cmd_rdy", 80'(cmd_Tready), 80'(0));
        chk("rst_tvalid", 80'(m_dm_cmd_tvalid), 80'(0));
        chk("rst_tdata", m_dm_cmd_tdata, 80'h0);
        chk("rst_sts_rdy", 80'(s_dm_sts_tready), 80'(0));
        chk("rst_outs", {77'h0, prRwDone, prRwError}, 80'h0);
        chk("rst_dmerr", 80'(dmError), 80'(0));
        aresetn = 1'b1;
        tick();
        chk("post_rst_cmd_rdy", 80'(cmd_Tready), 80'(1));
        chk("post_rst_sts_rdy", 80'(s_dm_sts_tready), 80'(1));
    endtask

    initial begin
        // Reset
        do_reset();

        // Single chunk command
        cap.delete();
        send_cmd(8'h01, 40'h12_0000_0000, 32'h100);
        chk("t1_first_vld", 80'(m_dm_cmd_tvalid), 80'(1));
        wait_cap(1);
        if (cap.size() >= 1)
            chk("t1_word", cap[0], dm_word(4'h0, 40'h12_0000_0000, 1'b1, 23'h100));
        send_sts(8'h80);
        expect_done("t1", 2'b00);
        chk("t1_dmerr", 80'(dm_err_cnt), 80'(0));

        // Three chunks with 40-bit address wrap, outstanding limit, stall, slverr
        do_reset();
        cap.delete();
        send_cmd(8'h01, 40'hFF_FFC0_0000, 32'h00A0_0000);
        wait_cap(2);
        repeat (4) tick();
        chk("t2_limit_vld", 80'(m_dm_cmd_tvalid), 80'(0));
        chk("t2_limit_cnt", 80'(cap.size()), 80'(2));
        m_dm_cmd_tready = 1'b0;
        send_sts(8'h80);
        w2 = dm_word(4'h2, 40'h00_0040_0000, 1'b1, 23'h20_0000);
        for (int i = 0; i < 3; i++) begin
            chk("t2_stall_vld", 80'(m_dm_cmd_tvalid), 80'(1));
            chk("t2_stall_dat", m_dm_cmd_tdata, w2);
            tick();
        end
        m_dm_cmd_tready = 1'b1;
        wait_cap(3);
        if (cap.size() >= 3) begin
            chk("t2_word0", cap[0], dm_word(4'h0, 40'hFF_FFC0_0000, 1'b0, 23'h40_0000));
            chk("t2_word1", cap[1], dm_word(4'h1, 40'h00_0000_0000, 1'b0, 23'h40_0000));
            chk("t2_word2", cap[2], w2);
        end
        send_sts(8'h41);
        send_sts(8'h82);
        expect_done("t2", 2'b01);
        chk("t2_dmerr", 80'(dm_err_cnt), 80'(0));

        // Tag mismatch with nothing outstanding: dmError the next cycle only
        send_sts(8'h85);
        chk("t4_dmerr_pulse", 80'(dmError), 80'(1));
        tick();
        chk("t4_dmerr_clear", 80'(dmError), 80'(0));

        // Illegal commands, then a normal one
        do_reset();
        cap.delete();
        vld_before = vld_cycles;
        send_cmd(8'h02, 40'h00_0000_1000, 32'h100);
        expect_done("ill_op", 2'b10);
        send_cmd(8'h01, 40'h00_0000_1000, 32'h0);
        expect_done("ill_sz", 2'b10);
        chk("ill_no_vld", 80'(vld_cycles - vld_before), 80'(0));
        send_cmd(8'h01, 40'h00_0000_1000, 32'h40);
        wait_cap(1);
        if (cap.size() >= 1)
            chk("t5_word", cap[0], dm_word(4'h0, 40'h00_0000_1000, 1'b1, 23'h40));
        send_sts(8'h80);
        expect_done("t5", 2'b00);

        // Reset in the middle of issuing
        cap.delete();
        m_dm_cmd_tready = 1'b0;
        send_cmd(8'h01, 40'h00_1000_0000, 32'h0140_0000);
        chk("t6_issuing", 80'(m_dm_cmd_tvalid), 80'(1));
        do_reset();
        m_dm_cmd_tready = 1'b1;
        send_cmd(8'h01, 40'h00_2000_0000, 32'h100);
        wait_cap(1);
        if (cap.size() >= 1)
            chk("t6_word_tag0", cap[0], dm_word(4'h0, 40'h00_2000_0000, 1'b1, 23'h100));
        send_sts(8'h80);
        expect_done("t6", 2'b00);
        chk("final_dmerr", 80'(dm_err_cnt), 80'(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
